// File: rtl/imem_pkg.sv
// Shared controller state encoding and the NOP instruction that the
// fetch path returns for rejected addresses.
package imem_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } imem_state_e;

    // RISC-V "addi x0, x0, 0"
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_bank.sv
// Instruction storage: one synchronous read port and one byte-enabled
// synchronous write port; a same-cycle read sees the old word.
module imem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int NB    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NB-1:0]     wr_be
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The array itself has no reset; it is cleared by the controller's sweep.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory controller: clears the bank after reset, then
// serves fetches with one-cycle latency and accepts program-load writes.
module instr_fetch_mem #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req_valid,
    output logic                fetch_req_ready,
    input  logic [ADDR_W-1:0]   fetch_req_addr,
    output logic                fetch_rsp_valid,
    input  logic                fetch_rsp_ready,
    output logic [DATA_W-1:0]   fetch_rsp_instr,
    output logic [ADDR_W-1:0]   fetch_rsp_addr,
    output logic                fetch_rsp_err,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [DATA_W-1:0]   load_data,
    input  logic [DATA_W/8-1:0] load_be,
    output logic                load_err,
    output logic                init_busy
);

    import imem_pkg::*;

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(NB);

    localparam logic [ADDR_W-1:0] OFF_MASK      = ADDR_W'((64'(1) << OFF_W) - 64'(1));
    localparam logic [ADDR_W-1:0] IN_RANGE_MASK = ADDR_W'((64'(1) << (OFF_W + IDX_W)) - 64'(1));
    localparam logic [DATA_W-1:0] NOP_WORD      = DATA_W'(NOP_INSTR);

    localparam logic [0:0] ST_INIT  = INIT;
    localparam logic [0:0] ST_READY = READY;

    logic [0:0]        state;
    logic [IDX_W-1:0]  sweep_idx;
    logic              fetch_fire;
    logic              fetch_bad;
    logic              load_fire;
    logic              load_bad;
    logic [IDX_W-1:0]  fetch_idx;
    logic [IDX_W-1:0]  load_idx;
    logic              rd_en;
    logic [DATA_W-1:0] bank_rd_data;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;

    // Misaligned if any byte-offset bit is set; out of range if any bit
    // above the word-index field is set.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return ((a & OFF_MASK) != '0) || ((a & ~IN_RANGE_MASK) != '0);
    endfunction

    assign init_busy       = (state == ST_INIT);
    assign load_ready      = (state == ST_READY);
    assign fetch_req_ready = (state == ST_READY) && (!fetch_rsp_valid || fetch_rsp_ready);

    assign fetch_fire = fetch_req_valid && fetch_req_ready;
    assign load_fire  = load_valid && load_ready;
    assign fetch_bad  = addr_bad(fetch_req_addr);
    assign load_bad   = addr_bad(load_addr);
    assign fetch_idx  = fetch_req_addr[OFF_W +: IDX_W];
    assign load_idx   = load_addr[OFF_W +: IDX_W];

    // Rejected fetches never touch the bank, so the read register keeps its
    // old word and the output mux substitutes the NOP.
    assign rd_en           = fetch_fire && !fetch_bad;
    assign fetch_rsp_instr = fetch_rsp_err ? NOP_WORD : bank_rd_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = load_idx;
        wr_data = load_data;
        wr_be   = load_be;
        if (state == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = sweep_idx;
            wr_data = '0;
            wr_be   = '1;
        end else if (load_fire && !load_bad) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
        end else if (state == ST_INIT) begin
            if (sweep_idx == IDX_W'(DEPTH - 1)) begin
                state     <= ST_READY;
                sweep_idx <= '0;
            end else begin
                sweep_idx <= sweep_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_rsp_valid <= 1'b0;
            fetch_rsp_addr  <= '0;
            fetch_rsp_err   <= 1'b0;
            load_err        <= 1'b0;
        end else begin
            if (fetch_fire) begin
                fetch_rsp_valid <= 1'b1;
                fetch_rsp_addr  <= fetch_req_addr;
                fetch_rsp_err   <= fetch_bad;
            end else if (fetch_rsp_ready) begin
                fetch_rsp_valid <= 1'b0;
            end
            load_err <= load_fire && load_bad;
        end
    end

    imem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .rd_idx  (fetch_idx),
        .rd_data (bank_rd_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_be   (wr_be)
    );

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: a reference memory model predicts
// every response, handshake signal and load error cycle by cycle.
module tb_instr_fetch_mem;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_req_valid = 1'b0;
    logic        fetch_req_ready;
    logic [31:0] fetch_req_addr = '0;
    logic        fetch_rsp_valid;
    logic        fetch_rsp_ready = 1'b1;
    logic [31:0] fetch_rsp_instr;
    logic [31:0] fetch_rsp_addr;
    logic        fetch_rsp_err;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic [3:0]  load_be = '0;
    logic        load_err;
    logic        init_busy;

    always #5 clk = ~clk;

    instr_fetch_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_ready (fetch_req_ready),
        .fetch_req_addr  (fetch_req_addr),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_ready (fetch_rsp_ready),
        .fetch_rsp_instr (fetch_rsp_instr),
        .fetch_rsp_addr  (fetch_rsp_addr),
        .fetch_rsp_err   (fetch_rsp_err),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .load_be         (load_be),
        .load_err        (load_err),
        .init_busy       (init_busy)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } rsp_t;

    rsp_t        expQ[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        expLoadErr = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic badAddr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:8] != 24'h0);
    endfunction

    function automatic rsp_t expectFetch(input logic [31:0] a);
        rsp_t r;
        r.addr = a;
        if (badAddr(a)) begin
            r.instr = NOP;
            r.err   = 1'b1;
        end else begin
            r.instr = model[a[7:2]];
            r.err   = 1'b0;
        end
        return r;
    endfunction

    // One clock cycle: drive just after the rising edge, check at the falling
    // edge, then advance the model as the DUT will at the next rising edge.
    task automatic applyStimulus(input logic fv, input logic [31:0] fa,
                                 input logic lv, input logic [31:0] la,
                                 input logic [31:0] ld, input logic [3:0] lbe,
                                 input logic rr);
        logic rdy;
        logic expRspValid;
        logic fAcc;
        logic lAcc;
        rsp_t e;
        fetch_req_valid = fv;
        fetch_req_addr  = fa;
        load_valid      = lv;
        load_addr       = la;
        load_data       = ld;
        load_be         = lbe;
        fetch_rsp_ready = rr;
        @(negedge clk);
        rdy         = (cyc >= DEPTH);
        expRspValid = (expQ.size() != 0);
        checkOutput("init_busy", 64'(init_busy), 64'(!rdy));
        checkOutput("load_ready", 64'(load_ready), 64'(rdy));
        checkOutput("fetch_req_ready", 64'(fetch_req_ready), 64'(rdy && (!expRspValid || rr)));
        checkOutput("rsp_valid", 64'(fetch_rsp_valid), 64'(expRspValid));
        checkOutput("load_err", 64'(load_err), 64'(expLoadErr));
        if (expRspValid) begin
            e = expQ[0];
            checkOutput("rsp_instr", 64'(fetch_rsp_instr), 64'(e.instr));
            checkOutput("rsp_addr", 64'(fetch_rsp_addr), 64'(e.addr));
            checkOutput("rsp_err", 64'(fetch_rsp_err), 64'(e.err));
            if (rr) begin
                void'(expQ.pop_front());
            end
        end
        fAcc = fv && rdy && (!expRspValid || rr);
        lAcc = lv && rdy;
        if (fAcc) begin
            expQ.push_back(expectFetch(fa));
        end
        expLoadErr = lAcc && badAddr(la);
        if (lAcc && !badAddr(la)) begin
            for (int b = 0; b < 4; b++) begin
                if (lbe[b]) begin
                    model[la[7:2]][b*8 +: 8] = ld[b*8 +: 8];
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        end
    endtask

    task automatic fetchOnly(input logic [31:0] a);
        applyStimulus(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic loadOnly(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        applyStimulus(1'b0, 32'h0, 1'b1, a, d, be, 1'b1);
    endtask

    task automatic doReset();
        rst_n           = 1'b0;
        fetch_req_valid = 1'b0;
        load_valid      = 1'b0;
        fetch_rsp_ready = 1'b1;
        #1;
        checkOutput("rst_init_busy", 64'(init_busy), 64'(1));
        checkOutput("rst_rsp_valid", 64'(fetch_rsp_valid), 64'(0));
        checkOutput("rst_fetch_ready", 64'(fetch_req_ready), 64'(0));
        checkOutput("rst_load_ready", 64'(load_ready), 64'(0));
        checkOutput("rst_rsp_instr", 64'(fetch_rsp_instr), 64'(0));
        checkOutput("rst_rsp_addr", 64'(fetch_rsp_addr), 64'(0));
        checkOutput("rst_rsp_err", 64'(fetch_rsp_err), 64'(0));
        checkOutput("rst_load_err", 64'(load_err), 64'(0));
        expQ.delete();
        expLoadErr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        logic [31:0] fa;
        logic [31:0] la;
        $display("[TB] start");
        @(posedge clk);
        #1;
        doReset();

        // Requests during the sweep must be ignored; reset hits at index 30.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 32'h0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 1'b1);
        end
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h8, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 1'b1);
        end

        $display("[TB] basic fetch and load");
        fetchOnly(32'h00);
        loadOnly(32'h04, 32'h0050_0113, 4'hF);
        fetchOnly(32'h04);
        idleCycles(1);

        $display("[TB] bad addresses");
        fetchOnly(32'h02);
        fetchOnly(32'h100);
        loadOnly(32'h101, 32'h1234_5678, 4'hF);
        loadOnly(32'h100, 32'h1234_5678, 4'hF);
        fetchOnly(32'h00);
        fetchOnly(32'h04);
        idleCycles(1);

        $display("[TB] read-before-write");
        loadOnly(32'h08, 32'h1122_3344, 4'hF);
        applyStimulus(1'b1, 32'h08, 1'b1, 32'h08, 32'hAABB_CCDD, 4'b0011, 1'b1);
        fetchOnly(32'h08);
        idleCycles(1);

        $display("[TB] zero byte-enable and back-to-back loads");
        loadOnly(32'h0C, 32'hFFFF_FFFF, 4'h0);
        fetchOnly(32'h0C);
        loadOnly(32'h10, 32'h0102_0304, 4'hF);
        loadOnly(32'h10, 32'hAAAA_AAAA, 4'b0110);
        loadOnly(32'h10, 32'h5555_5555, 4'b0010);
        fetchOnly(32'h10);
        idleCycles(1);

        $display("[TB] backpressure stream");
        fetchOnly(32'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h04, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        end
        fetchOnly(32'h04);
        fetchOnly(32'h08);
        idleCycles(1);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            fa = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
            la = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) fa = fa | 32'h2;
            if ($urandom_range(0, 9) == 0) fa = fa | 32'h400;
            if ($urandom_range(0, 7) == 0) la = la | 32'h1;
            if ($urandom_range(0, 9) == 0) la = la | 32'h200;
            applyStimulus(1'($urandom_range(0, 1)), fa, 1'($urandom_range(0, 1)), la,
                          32'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end
        idleCycles(2);

        $display("[TB] reset with response pending");
        applyStimulus(1'b1, 32'h08, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        doReset();
        idleCycles(DEPTH);
        fetchOnly(32'h08);
        fetchOnly(32'h04);
        idleCycles(2);

        checkOutput("drain", 64'(expQ.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch/load address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width in bits; multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 64, word count; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports fetch_req_valid  input  1, fetch_req_ready  output  1, fetch_req_addr  input  ADDR_W, forming the byte-addressed fetch request channel.
REQ-007 SHALL have ports fetch_rsp_valid  output  1, fetch_rsp_ready  input  1, fetch_rsp_instr  output  DATA_W, fetch_rsp_addr  output  ADDR_W, fetch_rsp_err  output  1, forming the fetch response channel.
REQ-008 SHALL have ports load_valid  input  1, load_ready  output  1, load_addr  input  ADDR_W, load_data  input  DATA_W, load_be  input  DATA_W/8, forming the program-load write channel.
REQ-009 SHALL have port load_err  output  1  one-cycle pulse for a rejected load.
REQ-010 SHALL have port init_busy  output  1  high while the memory clear sweep runs.

Function
REQ-011 SHALL implement FSM states INIT and READY; reset enters INIT.
REQ-012 In INIT: write zero to one word per cycle, index 0 to DEPTH-1; after writing DEPTH-1 go to READY; init_busy=1 only in INIT; sweep takes exactly DEPTH cycles.
REQ-013 In INIT: fetch_req_ready=0, load_ready=0; channel inputs ignored.
REQ-014 fetch_req_ready SHALL equal (state==READY) && (!fetch_rsp_valid || fetch_rsp_ready).
REQ-015 Accepted fetch (valid&&ready) SHALL present its response registered in the next cycle: fetch latency 1, throughput 1 per cycle under no backpressure.
REQ-016 While fetch_rsp_valid && !fetch_rsp_ready, fetch_rsp_instr, fetch_rsp_addr and fetch_rsp_err SHALL hold stable.
REQ-017 fetch_rsp_valid SHALL clear after a response handshake with no new request accepted in the same cycle.
REQ-018 Word index = addr[log2(DATA_W/8) +: log2(DEPTH)]; addr is misaligned if low log2(DATA_W/8) bits are nonzero; out of range if any bit above the index field is set.
REQ-019 Misaligned or out-of-range fetch SHALL respond with err=1 and instr = NOP (0x00000013, zero-extended for DATA_W>32); no memory read side effects.
REQ-020 load_ready SHALL equal (state==READY); an accepted load writes only bytes whose load_be bit is 1.
REQ-021 Misaligned or out-of-range load SHALL NOT write; load_err SHALL pulse high the following cycle.
REQ-022 Load with load_be all zero SHALL be accepted, write nothing, and not flag an error.
REQ-023 Same-cycle accepted fetch and load to the same word: fetch SHALL return the pre-write data (read-before-write); the next fetch SHALL return new data.
REQ-024 Back-to-back loads to the same word SHALL apply in order; later bytes win.

Reset
REQ-025 rst_n low SHALL asynchronously force: state=INIT, sweep index=0, fetch_rsp_valid=0, fetch_rsp_instr=0, fetch_rsp_addr=0, fetch_rsp_err=0, load_err=0; init_busy reads 1 as soon as reset is asserted; fetch_req_ready=0, load_ready=0.
REQ-026 Reset asserted mid-sweep or mid-transfer SHALL discard any pending response and restart the full sweep after release.
REQ-027 Memory array contents SHALL NOT be reset directly; they are cleared only by the sweep.

Structure
REQ-028 Package imem_pkg SHALL hold the state enum (INIT, READY) and the NOP encoding constant.
REQ-029 Storage SHALL reside in sub-module imem_bank: DEPTH x DATA_W, one synchronous read port, one synchronous byte-enabled write port, read-before-write.
REQ-030 Controller (FSM, sweep counter, handshake, address checks) SHALL reside in instr_fetch_mem.

Verification
REQ-031 Reset release, DEPTH=64 -> init_busy high exactly 64 cycles; then fetch 0x00 returns 0x00000000, err=0.
REQ-032 Load 0x00500113 at 0x04 with be=4'hF, then fetch 0x04 -> rsp 0x00500113 one cycle after accept, err=0.
REQ-033 Fetch 0x02 and fetch 0x100 (DEPTH=64) -> err=1, instr=0x00000013; load to 0x101 -> load_err pulse, memory unchanged.
REQ-034 Word 0x08=0x11223344; same cycle fetch 0x08 plus load 0xAABBCCDD be=4'b0011 -> rsp 0x11223344; next fetch -> 0x1122CCDD.
REQ-035 Stream fetches 0x00,0x04,0x08 with fetch_rsp_ready low 3 cycles -> response held stable, fetch_req_ready=0, all three returned in order, none lost.
REQ-036 Assert rst_n low at sweep index 30 with fetch pending -> fetch_rsp_valid=0 immediately; after release, full 64-cycle sweep repeats.
